lr_ctrl: RTL and testbench



---
 rtl/d16_lr_pkg.sv | 30 +++
 rtl/lr_stack_mem.sv | 45 ++++
 rtl/lr_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lr_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/d16_lr_pkg.sv
// -----------------------------------------------------------------------------
// d16_lr_pkg
// Shared definitions for the d16 link-register controller: grant encoding,
// default geometry and small helpers used by the arbiter.
// -----------------------------------------------------------------------------
package d16_lr_pkg;

   localparam int LR_WIDTH = 16;   // default address/data width
   localparam int LR_DEPTH = 4;    // default return-stack entries

   // One value per possible winner of the link-register write arbitration.
   typedef enum logic [2:0] {
      GNT_NONE = 3'd0,
      GNT_IRQ  = 3'd1,
      GNT_CALL = 3'd2,
      GNT_RET  = 3'd3,
      GNT_WR   = 3'd4
   } gnt_e;

   // Interrupt entry and call both save the current LR onto the stack.
   function automatic logic gnt_is_push(input gnt_e g);
      return (g == GNT_IRQ) || (g == GNT_CALL);
   endfunction

   // Only a return reads the stack.
   function automatic logic gnt_is_pop(input gnt_e g);
      return (g == GNT_RET);
   endfunction

endpackage

// File: rtl/lr_stack_mem.sv
// -----------------------------------------------------------------------------
// lr_stack_mem
// DEPTH x WIDTH register file holding the hardware return-address stack.
// One synchronous write port, one asynchronous read port, synchronous
// active-high reset clearing every entry to zero.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset (clears all entries)
//   wr_en    - write strobe
//   wr_addr  - entry written on the rising edge when wr_en is high
//   wr_data  - value written
//   rd_addr  - entry presented on rd_data
//   rd_data  - combinational read data
// -----------------------------------------------------------------------------
module lr_stack_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Entry storage: cleared on reset, otherwise written at wr_addr on wr_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/lr_ctrl.sv
// -----------------------------------------------------------------------------
// lr_ctrl
// Link-register controller for the d16 core. Arbitrates writes to the link
// register (irq > call > ret > wr), keeps a circular hardware return-address
// stack and reports sticky overflow/underflow.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   irq_req / irq_addr    - interrupt entry: push lr_cur, load irq_addr
//   call_req / call_addr  - call: push lr_cur, load call_addr
//   ret_req               - return: pop stack top into LR (0 if empty)
//   wr_req / wr_data      - explicit LR write, no stack effect
//   lr_cur                - current link register value
//   clr_flags             - clears sticky ovf/unf
//   irq_ack .. wr_ack     - one-hot combinational grants
//   lr_wr_en / lr_in      - link register write enable and data
//   depth                 - number of valid stack entries (0..DEPTH)
//   ovf / unf             - sticky push-while-full / pop-while-empty
// -----------------------------------------------------------------------------
module lr_ctrl
   import d16_lr_pkg::*;
#(
   parameter int DEPTH = LR_DEPTH,
   parameter int WIDTH = LR_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     irq_req,
   input  logic [WIDTH-1:0]         irq_addr,
   input  logic                     call_req,
   input  logic [WIDTH-1:0]         call_addr,
   input  logic                     ret_req,
   input  logic                     wr_req,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [WIDTH-1:0]         lr_cur,
   input  logic                     clr_flags,
   output logic                     irq_ack,
   output logic                     call_ack,
   output logic                     ret_ack,
   output logic                     wr_ack,
   output logic                     lr_wr_en,
   output logic [WIDTH-1:0]         lr_in,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     ovf,
   output logic                     unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
   localparam logic [DW-1:0] DEPTH_ONE  = DW'(1'b1);
   localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

   gnt_e             gnt_s;
   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             empty_s;
   logic [AW-1:0]    top_addr_s;
   logic [WIDTH-1:0] top_data_s;

   logic [AW-1:0]    sp_r;
   logic [DW-1:0]    depth_r;
   logic             ovf_r;
   logic             unf_r;

   logic [AW-1:0]    sp_nxt_s;
   logic [DW-1:0]    depth_nxt_s;
   logic             ovf_set_s;
   logic             unf_set_s;

   assign full_s     = (depth_r == DEPTH_FULL);
   assign empty_s    = (depth_r == {DW{1'b0}});
   // Stack top lives one below the write pointer; the pointer wraps, so
   // after an overflow the newest entries are still the ones popped first.
   assign top_addr_s = sp_r - PTR_ONE;
   assign push_s     = gnt_is_push(gnt_s);
   assign pop_s      = gnt_is_pop(gnt_s);

   lr_stack_mem #(
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .AW      (AW)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_s),
      .wr_addr (sp_r),
      .wr_data (lr_cur),
      .rd_addr (top_addr_s),
      .rd_data (top_data_s)
   );

   // Fixed-priority arbiter; reset suppresses every grant.
   always_comb begin
      gnt_s = GNT_NONE;
      if (rst) begin
         gnt_s = GNT_NONE;
      end else if (irq_req) begin
         gnt_s = GNT_IRQ;
      end else if (call_req) begin
         gnt_s = GNT_CALL;
      end else if (ret_req) begin
         gnt_s = GNT_RET;
      end else if (wr_req) begin
         gnt_s = GNT_WR;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   // Grant decode: acks and link-register write data.
   always_comb begin
      irq_ack  = 1'b0;
      call_ack = 1'b0;
      ret_ack  = 1'b0;
      wr_ack   = 1'b0;
      lr_in    = {WIDTH{1'b0}};
      case (gnt_s)
         GNT_IRQ: begin
            irq_ack = 1'b1;
            lr_in   = irq_addr;
         end
         GNT_CALL: begin
            call_ack = 1'b1;
            lr_in    = call_addr;
         end
         GNT_RET: begin
            // An empty pop is still acknowledged but loads zero.
            ret_ack = 1'b1;
            if (empty_s) begin
               lr_in = {WIDTH{1'b0}};
            end else begin
               lr_in = top_data_s;
            end
         end
         GNT_WR: begin
            wr_ack = 1'b1;
            lr_in  = wr_data;
         end
         GNT_NONE: begin
            lr_in = {WIDTH{1'b0}};
         end
         default: begin
            lr_in = {WIDTH{1'b0}};
         end
      endcase
      lr_wr_en = irq_ack | call_ack | ret_ack | wr_ack;
   end

   // Next stack pointer, occupancy and flag-set conditions.
   always_comb begin
      sp_nxt_s    = sp_r;
      depth_nxt_s = depth_r;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      if (push_s) begin
         sp_nxt_s = sp_r + PTR_ONE;
         if (full_s) begin
            // Oldest entry is overwritten; occupancy saturates.
            depth_nxt_s = depth_r;
            ovf_set_s   = 1'b1;
         end else begin
            depth_nxt_s = depth_r + DEPTH_ONE;
         end
      end else if (pop_s) begin
         if (empty_s) begin
            unf_set_s = 1'b1;
         end else begin
            sp_nxt_s    = top_addr_s;
            depth_nxt_s = depth_r - DEPTH_ONE;
         end
      end else begin
         sp_nxt_s    = sp_r;
         depth_nxt_s = depth_r;
      end
   end

   // Pointer, occupancy and sticky flags; a new event beats clr_flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_r    <= {AW{1'b0}};
         depth_r <= {DW{1'b0}};
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         sp_r    <= sp_nxt_s;
         depth_r <= depth_nxt_s;
         ovf_r   <= ovf_set_s | (ovf_r & ~clr_flags);
         unf_r   <= unf_set_s | (unf_r & ~clr_flags);
      end
   end

   assign depth = depth_r;
   assign ovf   = ovf_r;
   assign unf   = unf_r;

endmodule

// File: tb/tb_lr_ctrl.sv
module tb_lr_ctrl;
   import d16_lr_pkg::*;

   localparam int DEPTH = 4;
   localparam int WIDTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        irq_req, call_req, ret_req, wr_req, clr_flags;
   logic [15:0] irq_addr, call_addr, wr_data, lr_cur;
   logic        irq_ack, call_ack, ret_ack, wr_ack, lr_wr_en;
   logic [15:0] lr_in;
   logic [2:0]  depth;
   logic        ovf, unf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lr_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .irq_req(irq_req), .irq_addr(irq_addr),
      .call_req(call_req), .call_addr(call_addr),
      .ret_req(ret_req), .wr_req(wr_req), .wr_data(wr_data),
      .lr_cur(lr_cur), .clr_flags(clr_flags),
      .irq_ack(irq_ack), .call_ack(call_ack), .ret_ack(ret_ack), .wr_ack(wr_ack),
      .lr_wr_en(lr_wr_en), .lr_in(lr_in), .depth(depth), .ovf(ovf), .unf(unf)
   );

   typedef struct {
      logic        rst;
      logic        irq;
      logic [15:0] irq_addr;
      logic        call;
      logic [15:0] call_addr;
      logic        ret;
      logic        wr;
      logic [15:0] wr_data;
      logic [15:0] lr_cur;
      logic        clr;
      logic [3:0]  acks;    // {irq, call, ret, wr}
      logic [15:0] lr_in;   // compared only when a grant is expected
      logic [2:0]  depth;   // value before this cycle's edge
      logic        ovf;
      logic        unf;
   } vec_t;

   function automatic vec_t mk(
      input logic r, input logic i, input logic [15:0] ia,
      input logic c, input logic [15:0] ca, input logic rt,
      input logic w, input logic [15:0] wd, input logic [15:0] lc,
      input logic cl, input logic [3:0] ea, input logic [15:0] el,
      input logic [2:0] ed, input logic eo, input logic eu);
      vec_t v;
      v.rst = r; v.irq = i; v.irq_addr = ia; v.call = c; v.call_addr = ca;
      v.ret = rt; v.wr = w; v.wr_data = wd; v.lr_cur = lc; v.clr = cl;
      v.acks = ea; v.lr_in = el; v.depth = ed; v.ovf = eo; v.unf = eu;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; irq_req = v.irq; irq_addr = v.irq_addr;
      call_req = v.call; call_addr = v.call_addr; ret_req = v.ret;
      wr_req = v.wr; wr_data = v.wr_data; lr_cur = v.lr_cur; clr_flags = v.clr;
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      #1;
      check({tag, " acks"}, {12'd0, irq_ack, call_ack, ret_ack, wr_ack}, {12'd0, v.acks});
      check({tag, " lr_wr_en"}, {15'd0, lr_wr_en}, {15'd0, |v.acks});
      if (v.acks != 4'b0000) check({tag, " lr_in"}, lr_in, v.lr_in);
      check({tag, " depth"}, {13'd0, depth}, {13'd0, v.depth});
      check({tag, " ovf"}, {15'd0, ovf}, {15'd0, v.ovf});
      check({tag, " unf"}, {15'd0, unf}, {15'd0, v.unf});
   endtask

   vec_t tbl[27];
   vec_t v;

   // reference model state for the random phase
   logic [15:0] mq[$];
   logic        m_ovf, m_unf;

   initial begin
      // rst irq ia        call ca        ret wr wd        lr_cur    clr  acks     lr_in     dep  ovf unf
      tbl[0]  = mk(1'b1,1'b1,16'h1111,1'b1,16'h2222,1'b1,1'b1,16'h3333,16'h4444,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b0);
      tbl[1]  = mk(1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0000,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b0);
      // nested calls and returns
      tbl[2]  = mk(1'b0,1'b0,16'h0000,1'b1,16'h0102,1'b0,1'b0,16'h0000,16'h0000,1'b0, 4'b0100,16'h0102,3'd0,1'b0,1'b0);
      tbl[3]  = mk(1'b0,1'b0,16'h0000,1'b1,16'h0204,1'b0,1'b0,16'h0000,16'h0102,1'b0, 4'b0100,16'h0204,3'd1,1'b0,1'b0);
      tbl[4]  = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0204,1'b0, 4'b0010,16'h0102,3'd2,1'b0,1'b0);
      tbl[5]  = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0102,1'b0, 4'b0010,16'h0000,3'd1,1'b0,1'b0);
      tbl[6]  = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b0);
      // priority
      tbl[7]  = mk(1'b0,1'b1,16'h0800,1'b1,16'h0900,1'b0,1'b1,16'h0A00,16'h0000,1'b0, 4'b1000,16'h0800,3'd0,1'b0,1'b0);
      tbl[8]  = mk(1'b0,1'b0,16'h0000,1'b1,16'h0900,1'b0,1'b1,16'h0A00,16'h0800,1'b0, 4'b0100,16'h0900,3'd1,1'b0,1'b0);
      tbl[9]  = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h0A00,16'h0900,1'b0, 4'b0001,16'h0A00,3'd2,1'b0,1'b0);
      tbl[10] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b1,16'h0A00,16'h0A00,1'b0, 4'b0010,16'h0800,3'd2,1'b0,1'b0);
      tbl[11] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0800,1'b0, 4'b0010,16'h0000,3'd1,1'b0,1'b0);
      // underflow and flag clear
      tbl[12] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0000,1'b0, 4'b0010,16'h0000,3'd0,1'b0,1'b0);
      tbl[13] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b1);
      tbl[14] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1, 4'b0000,16'h0000,3'd0,1'b0,1'b1);
      tbl[15] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b0);
      // underflow in the same cycle as clr_flags: the flag is set
      tbl[16] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0000,1'b1, 4'b0010,16'h0000,3'd0,1'b0,1'b0);
      tbl[17] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b1);
      tbl[18] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1, 4'b0000,16'h0000,3'd0,1'b0,1'b1);
      tbl[19] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b0);
      // explicit write between call and ret
      tbl[20] = mk(1'b0,1'b0,16'h0000,1'b1,16'h0300,1'b0,1'b0,16'h0000,16'h1234,1'b0, 4'b0100,16'h0300,3'd0,1'b0,1'b0);
      tbl[21] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'hBEEF,16'h0300,1'b0, 4'b0001,16'hBEEF,3'd1,1'b0,1'b0);
      tbl[22] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'hBEEF,1'b0, 4'b0010,16'h1234,3'd1,1'b0,1'b0);
      tbl[23] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h1234,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b0);
      // reset with a pending request and a non-empty stack
      tbl[24] = mk(1'b0,1'b0,16'h0000,1'b1,16'h0400,1'b0,1'b0,16'h0000,16'h0001,1'b0, 4'b0100,16'h0400,3'd0,1'b0,1'b0);
      tbl[25] = mk(1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0400,1'b0, 4'b0000,16'h0000,3'd1,1'b0,1'b0);
      tbl[26] = mk(1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0, 4'b0000,16'h0000,3'd0,1'b0,1'b0);

      v = mk(1'b1,1'b0,16'h0,1'b0,16'h0,1'b0,1'b0,16'h0,16'h0,1'b0, 4'b0,16'h0,3'd0,1'b0,1'b0);
      drive(v);
      repeat (2) @(negedge clk);

      for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("vec%0d", i));

      // Overflow: five calls into a four-deep stack
      for (int i = 0; i < 5; i++) begin
         v = mk(1'b0,1'b0,16'h0,1'b1,16'(16'h1000 + i),1'b0,1'b0,16'h0,16'(16'h0010 * (i + 1)),1'b0,
                4'b0100,16'(16'h1000 + i),3'(i < 4 ? i : 4),1'b0,1'b0);
         step(v, $sformatf("ovf_call%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         v = mk(1'b0,1'b0,16'h0,1'b0,16'h0,1'b1,1'b0,16'h0,16'h7777,1'b0,
                4'b0010,16'(16'h0050 - 16'h0010 * i),3'(4 - i),1'b1,1'b0);
         step(v, $sformatf("ovf_ret%0d", i));
      end
      v = mk(1'b0,1'b0,16'h0,1'b0,16'h0,1'b0,1'b0,16'h0,16'h0,1'b1, 4'b0000,16'h0,3'd0,1'b1,1'b0);
      step(v, "ovf_clr");
      v = mk(1'b0,1'b0,16'h0,1'b0,16'h0,1'b0,1'b0,16'h0,16'h0,1'b0, 4'b0000,16'h0,3'd0,1'b0,1'b0);
      step(v, "ovf_cleared");

      // Random traffic against a queue-based model of the return stack
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic [3:0]  e_acks;
         logic [15:0] e_lr;
         @(negedge clk);
         rst       = (i == 0) || ($urandom_range(0, 63) == 0);
         irq_req   = ($urandom_range(0, 7) == 0);
         call_req  = ($urandom_range(0, 2) == 0);
         ret_req   = ($urandom_range(0, 1) == 0);
         wr_req    = ($urandom_range(0, 3) == 0);
         clr_flags = ($urandom_range(0, 15) == 0);
         irq_addr  = 16'($urandom);
         call_addr = 16'($urandom);
         wr_data   = 16'($urandom);
         lr_cur    = 16'($urandom);
         #1;
         e_acks = 4'b0000;
         e_lr   = 16'h0000;
         if (rst)           e_acks = 4'b0000;
         else if (irq_req)  begin e_acks = 4'b1000; e_lr = irq_addr;  end
         else if (call_req) begin e_acks = 4'b0100; e_lr = call_addr; end
         else if (ret_req)  begin e_acks = 4'b0010; e_lr = (mq.size() > 0) ? mq[$] : 16'h0000; end
         else if (wr_req)   begin e_acks = 4'b0001; e_lr = wr_data;   end
         check("rnd acks", {12'd0, irq_ack, call_ack, ret_ack, wr_ack}, {12'd0, e_acks});
         check("rnd lr_wr_en", {15'd0, lr_wr_en}, {15'd0, |e_acks});
         if (e_acks != 4'b0000) check("rnd lr_in", lr_in, e_lr);
         check("rnd depth", {13'd0, depth}, 16'(mq.size()));
         check("rnd ovf", {15'd0, ovf}, {15'd0, m_ovf});
         check("rnd unf", {15'd0, unf}, {15'd0, m_unf});
         // model update for the coming edge
         if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end else begin
            logic o_set, u_set;
            o_set = 1'b0;
            u_set = 1'b0;
            if (e_acks[3] || e_acks[2]) begin
               mq.push_back(lr_cur);
               if (mq.size() > DEPTH) begin
                  void'(mq.pop_front());
                  o_set = 1'b1;
               end
            end else if (e_acks[1]) begin
               if (mq.size() > 0) void'(mq.pop_back());
               else u_set = 1'b1;
            end
            m_ovf = o_set | (m_ovf & ~clr_flags);
            m_unf = u_set | (m_unf & ~clr_flags);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
